aes_128_dec_iter: RTL and testbench

- Iterative AES-128 decryptor: the inverse of the pipelined aes_128 encryptor.
- Accepts one 128-bit ciphertext and its 128-bit cipher key through a valid/ready handshake, and returns the plaintext through a valid/ready handshake.
- Derives round key 10 on-chip by running the forward key schedule, then runs the key schedule backwards while executing one inverse round per cycle.
- Sits on the receive side of the crypto datapath, with the same byte ordering as aes_128: byte 0 = bits [127:120].

---
 rtl/aes_128_dec_iter.sv | 214 +++++++++++++++++++++
 tb/tb_aes_128_dec_iter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryptor. The forward key schedule runs first to reach
// round key 10, then the schedule is walked backwards while one inverse round
// executes per cycle. Byte 0 of every 128-bit word is bits [127:120].
module aes_128_dec_iter #(
  parameter bit CLEAR_ON_POP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] s_q, s_d;
  logic [127:0] pt_q, pt_d;
  logic         ov_q, ov_d;

  logic [31:0]  a0, a1, a2, a3, b1, b2, b3, sw_in, t;
  logic [7:0]   rc;
  logic [127:0] rk_fwd, rk_inv, rnd_sub, rnd_mix;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); 0 maps to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h01;
    x = a;
    for (int unsigned i = 1; i < 8; i++) begin
      x = gmul(x, x);
      p = gmul(p, x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
             ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w))
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // InvShiftRows followed by InvSubBytes; byte index = row + 4*column.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   c0, c1, c2, c3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      c0 = s[127 - 32*c -: 8];
      c1 = s[119 - 32*c -: 8];
      c2 = s[111 - 32*c -: 8];
      c3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(c0, 8'h0e) ^ gmul(c1, 8'h0b) ^ gmul(c2, 8'h0d) ^ gmul(c3, 8'h09);
      o[119 - 32*c -: 8] = gmul(c0, 8'h09) ^ gmul(c1, 8'h0e) ^ gmul(c2, 8'h0b) ^ gmul(c3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(c0, 8'h0d) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0e) ^ gmul(c3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(c0, 8'h0b) ^ gmul(c1, 8'h0d) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0e);
    end
    return o;
  endfunction

  // Shared key-schedule step and inverse-round datapath. Forward and reverse
  // key steps share the same four S-boxes: only the word fed to SubWord and
  // the rcon index differ between KEYEXP and ROUND.
  always_comb begin
    {a0, a1, a2, a3} = rk_q;
    b3     = a3 ^ a2;
    b2     = a2 ^ a1;
    b1     = a1 ^ a0;
    sw_in  = (state_q == ROUND) ? b3 : a3;
    rc     = rcon((state_q == ROUND) ? cnt_q + 4'd1 : cnt_q);
    t      = sub_rot(sw_in) ^ {rc, 24'h0};
    rk_fwd = {a0 ^ t, a1 ^ a0 ^ t, a2 ^ a1 ^ a0 ^ t, a3 ^ a2 ^ a1 ^ a0 ^ t};
    rk_inv = {a0 ^ t, b1, b2, b3};
    rnd_sub = inv_shift_sub(s_q) ^ rk_inv;
    rnd_mix = inv_mix(rnd_sub);
  end

  // Next-state and datapath register updates; s_q holds the ciphertext
  // during KEYEXP so no separate ct register is needed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rk_d    = rk_q;
    s_d     = s_q;
    pt_d    = pt_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = ct;
          rk_d    = key;
          cnt_d   = 4'd1;
          state_d = KEYEXP;
        end
      end
      KEYEXP: begin
        rk_d = rk_fwd;
        if (cnt_q == 4'd10) begin
          s_d     = s_q ^ rk_fwd;
          cnt_d   = 4'd9;
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUND: begin
        rk_d = rk_inv;
        if (cnt_q == 4'd0) begin
          s_d     = rnd_sub;
          pt_d    = rnd_sub;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          s_d   = rnd_mix;
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
          if (CLEAR_ON_POP) pt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rk_q    <= '0;
      s_q     <= '0;
      pt_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
      s_q     <= s_d;
      pt_q    <= pt_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = ov_q;
  assign pt        = pt_q;
  assign busy      = (state_q == KEYEXP) || (state_q == ROUND);

endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Directed bench for aes_128_dec_iter: FIPS-197 vectors, handshake timing,
// output hold, mid-operation reset and round trips against an encrypt model.
module tb_aes_128_dec_iter;

  logic         clk, rst;
  logic         in_valid, in_ready;
  logic [127:0] ct, key;
  logic         out_valid, out_ready;
  logic [127:0] pt;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cyc = 0;
  bit acc_seen = 0;

  logic [7:0]   sb [256];
  logic [127:0] sbrows [16];

  aes_128_dec_iter #(.CLEAR_ON_POP(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; remembers the edge at which an input handshake happened.
  task automatic tick();
    bit hs;
    hs = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (hs) begin
      hs_cyc   = cyc;
      acc_seen = 1'b1;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
    w0 = w0 ^ t ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Reference AES-128 encryption, table-driven.
  function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s, t, rk;
    logic [7:0]   rc, x0, x1, x2, x3;
    s  = p ^ k;
    rk = k;
    rc = 8'h01;
    t  = '0;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      rk = kexp(rk, rc);
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sb[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          x0 = s[127-32*c -: 8];
          x1 = s[119-32*c -: 8];
          x2 = s[111-32*c -: 8];
          x3 = s[103-32*c -: 8];
          s[127-32*c -: 8] = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
          s[119-32*c -: 8] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
          s[111-32*c -: 8] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
          s[103-32*c -: 8] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
        end
      end
      s = s ^ rk;
    end
    return s;
  endfunction

  // Full transaction: accept, bounded wait with bus noise, check, pop.
  task automatic decrypt(input string tag, input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] p);
    int n;
    ct = c; key = k; in_valid = 1'b1; acc_seen = 1'b0; n = 0;
    while (!acc_seen && n < 30) begin tick(); n++; end
    check({tag, "_accept"}, {127'd0, acc_seen}, 128'd1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      ct = rnd128(); key = rnd128();
      tick(); n++;
    end
    check({tag, "_latency"}, 128'(cyc - hs_cyc), 128'd20);
    check({tag, "_pt"}, pt, p);
    tick();
    check({tag, "_pop_valid"}, {127'd0, out_valid}, 128'd0);
    check({tag, "_pop_clear"}, pt, 128'd0);
    check({tag, "_pop_ready"}, {127'd0, in_ready}, 128'd1);
  endtask

  localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_C   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_P   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_C   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    int n, hs_a;
    logic [127:0] rk, rp, rc;

    sbrows = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        sb[16*i+j] = sbrows[i][127-8*j -: 8];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ct = '0; key = '0;
    tick(); tick();
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_pt", pt, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", {127'd0, in_ready}, 128'd1);

    decrypt("c1", C1_K, C1_C, C1_P);
    decrypt("appb", B_K, B_C, B_P);

    // Zero key with the consumer stalled.
    out_ready = 1'b0;
    ct = Z_C; key = '0; in_valid = 1'b1; acc_seen = 1'b0; n = 0;
    while (!acc_seen && n < 30) begin tick(); n++; end
    in_valid = 1'b0;
    tick();
    check("zero_busy", {127'd0, busy}, 128'd1);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("zero_latency", 128'(cyc - hs_cyc), 128'd20);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("hold_valid", {127'd0, out_valid}, 128'd1);
      check("hold_pt", pt, 128'd0);
      check("hold_in_ready", {127'd0, in_ready}, 128'd0);
    end
    check("done_busy", {127'd0, busy}, 128'd0);
    out_ready = 1'b1;
    tick();
    check("zero_pop_valid", {127'd0, out_valid}, 128'd0);
    check("zero_pop_pt", pt, 128'd0);
    check("zero_pop_ready", {127'd0, in_ready}, 128'd1);

    // Back-to-back with in_valid held high and noise on the bus.
    ct = C1_C; key = C1_K; in_valid = 1'b1; acc_seen = 1'b0; n = 0;
    while (!acc_seen && n < 30) begin tick(); n++; end
    hs_a = hs_cyc;
    n = 0;
    while (!out_valid && n < 40) begin ct = rnd128(); key = rnd128(); tick(); n++; end
    check("b2b_a_latency", 128'(cyc - hs_a), 128'd20);
    check("b2b_a_pt", pt, C1_P);
    ct = B_C; key = B_K; acc_seen = 1'b0; n = 0;
    while (!acc_seen && n < 30) begin tick(); n++; end
    check("b2b_spacing", 128'(hs_cyc - hs_a), 128'd22);
    n = 0;
    while (!out_valid && n < 40) begin ct = rnd128(); key = rnd128(); tick(); n++; end
    in_valid = 1'b0;
    check("b2b_b_latency", 128'(cyc - hs_cyc), 128'd20);
    check("b2b_b_pt", pt, B_P);
    tick();
    check("b2b_pop_valid", {127'd0, out_valid}, 128'd0);

    // Reset twelve cycles into a block.
    ct = C1_C; key = C1_K; in_valid = 1'b1; acc_seen = 1'b0; n = 0;
    while (!acc_seen && n < 30) begin tick(); n++; end
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    rst = 1'b1;
    #1;
    check("abort_in_ready_rst", {127'd0, in_ready}, 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_out_valid", {127'd0, out_valid}, 128'd0);
    check("abort_pt", pt, 128'd0);
    check("abort_in_ready", {127'd0, in_ready}, 128'd1);
    check("abort_busy", {127'd0, busy}, 128'd0);
    n = 0;
    for (int i = 0; i < 25; i++) begin tick(); if (out_valid) n++; end
    check("abort_no_output", 128'(n), 128'd0);
    decrypt("c1_after_rst", C1_K, C1_C, C1_P);

    // Random round trips through the reference encryptor.
    for (int i = 0; i < 200; i++) begin
      rk = rnd128();
      rp = rnd128();
      rc = enc(rp, rk);
      decrypt("rt", rk, rc, rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
